// File: rtl/pixel_frame_streamer.sv
// -----------------------------------------------------------------------------
// pixel_frame_streamer
//
// Upstream feeder for the pixel UART serialiser. A single-cycle start pulse in
// IDLE makes the block present a two-word sync header (SYNC0, SYNC1), then read
// every pixel of one frame from the frame-buffer RAM in raster order. Each
// pixel is offered to the serialiser over a valid/ready handshake. A one-cycle
// frame_done pulse tells the capture side that the buffer may be released.
//
// Optional feature (compile-time macro PIXEL_FRAME_STREAMER_CHECKSUM_EN):
//   Adds a PIXEL_W-bit running sum of all transferred pixels (headers
//   excluded). A trailer word carrying the sum follows the last pixel, and
//   frame_done pulses after the trailer has been accepted.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   start      in   single-cycle request to stream one frame (IDLE only)
//   busy       out  high from the cycle after start is accepted until frame_done
//   frame_done out  one-cycle pulse after the final word is accepted
//   rd_addr    out  frame-buffer read address
//   rd_en      out  frame-buffer read strobe (one per pixel)
//   rd_data    in   frame-buffer data, valid one cycle after rd_en
//   pixel_out  out  word presented to the serialiser
//   valid_out  out  pixel_out is valid
//   ready_in   in   serialiser can accept a word
//
// All outputs come straight from flops. The frame-buffer must hold at least
// IMG_W*IMG_H words, so 2**ADDR_W >= IMG_W*IMG_H is required.
// -----------------------------------------------------------------------------
module pixel_frame_streamer #(
  parameter int                  IMG_W   = 320,
  parameter int                  IMG_H   = 240,
  parameter int                  ADDR_W  = 17,
  parameter int                  PIXEL_W = 12,
  parameter logic [PIXEL_W-1:0]  SYNC0   = 12'hA5A,
  parameter logic [PIXEL_W-1:0]  SYNC1   = 12'h5A5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               frame_done,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic               rd_en,
  input  logic [PIXEL_W-1:0] rd_data,
  output logic [PIXEL_W-1:0] pixel_out,
  output logic               valid_out,
  input  logic               ready_in
);

  // State encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SYNC_A  = 3'd1;
  localparam logic [2:0] ST_SYNC_B  = 3'd2;
  localparam logic [2:0] ST_FETCH   = 3'd3;
  localparam logic [2:0] ST_CAPTURE = 3'd4;
  localparam logic [2:0] ST_SEND    = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;
`ifdef PIXEL_FRAME_STREAMER_CHECKSUM_EN
  localparam logic [2:0] ST_TRAILER = 3'd7;
`endif

  // Index of the final pixel of a frame; the counter never moves past it.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);

  logic [2:0]          state_q,      state_d;
  logic [ADDR_W-1:0]   counter_q,    counter_d;
  logic                busy_q,       busy_d;
  logic                frame_done_q, frame_done_d;
  logic [ADDR_W-1:0]   rd_addr_q,    rd_addr_d;
  logic                rd_en_q,      rd_en_d;
  logic [PIXEL_W-1:0]  pixel_out_q,  pixel_out_d;
  logic                valid_out_q,  valid_out_d;
  logic                xfer;

`ifdef PIXEL_FRAME_STREAMER_CHECKSUM_EN
  logic [PIXEL_W-1:0]  csum_q,       csum_d;

  // Modulo-2^PIXEL_W accumulation of one pixel into the running checksum.
  function automatic logic [PIXEL_W-1:0] csum_add(input logic [PIXEL_W-1:0] acc,
                                                  input logic [PIXEL_W-1:0] pix);
    csum_add = acc + pix;
  endfunction
`endif

  // A word is handed over on an edge where the registered valid meets ready.
  assign xfer = valid_out_q & ready_in;

  // Next-state and next-output computation; outputs are set up one cycle
  // ahead so that every port is driven straight from a flop.
  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    rd_addr_d    = rd_addr_q;
    rd_en_d      = 1'b0;
    pixel_out_d  = pixel_out_q;
    valid_out_d  = valid_out_q;
`ifdef PIXEL_FRAME_STREAMER_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        counter_d = ADDR_ZERO;
`ifdef PIXEL_FRAME_STREAMER_CHECKSUM_EN
        csum_d    = {PIXEL_W{1'b0}};
`endif
        // frame_done_q is only high in IDLE right after a trailer; a start
        // coinciding with that pulse must be dropped.
        if (start && !frame_done_q) begin
          state_d     = ST_SYNC_A;
          busy_d      = 1'b1;
          valid_out_d = 1'b1;
          pixel_out_d = SYNC0;
        end else begin
          state_d     = ST_IDLE;
          valid_out_d = 1'b0;
        end
      end

      ST_SYNC_A: begin
        if (xfer) begin
          state_d     = ST_SYNC_B;
          pixel_out_d = SYNC1;
        end else begin
          state_d     = ST_SYNC_A;
        end
      end

      ST_SYNC_B: begin
        if (xfer) begin
          state_d     = ST_FETCH;
          valid_out_d = 1'b0;
          rd_en_d     = 1'b1;
          rd_addr_d   = counter_q;
        end else begin
          state_d     = ST_SYNC_B;
        end
      end

      ST_FETCH: begin
        // The read strobe is live during this cycle; data lands in CAPTURE.
        state_d = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        state_d     = ST_SEND;
        pixel_out_d = rd_data;
        valid_out_d = 1'b1;
      end

      ST_SEND: begin
        if (xfer) begin
          valid_out_d = 1'b0;
`ifdef PIXEL_FRAME_STREAMER_CHECKSUM_EN
          csum_d      = csum_add(csum_q, pixel_out_q);
`endif
          if (counter_q == LAST_IDX) begin
            state_d      = ST_DONE;
`ifdef PIXEL_FRAME_STREAMER_CHECKSUM_EN
            frame_done_d = 1'b0;
            busy_d       = 1'b1;
`else
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
`endif
          end else begin
            state_d   = ST_FETCH;
            counter_d = counter_q + ADDR_ONE;
            rd_en_d   = 1'b1;
            rd_addr_d = counter_q + ADDR_ONE;
          end
        end else begin
          state_d = ST_SEND;
        end
      end

      ST_DONE: begin
        counter_d = ADDR_ZERO;
`ifdef PIXEL_FRAME_STREAMER_CHECKSUM_EN
        // The running sum already includes the last pixel at this point.
        state_d     = ST_TRAILER;
        valid_out_d = 1'b1;
        pixel_out_d = csum_q;
`else
        state_d     = ST_IDLE;
`endif
      end

`ifdef PIXEL_FRAME_STREAMER_CHECKSUM_EN
      ST_TRAILER: begin
        if (xfer) begin
          state_d      = ST_IDLE;
          valid_out_d  = 1'b0;
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
        end else begin
          state_d      = ST_TRAILER;
        end
      end
`endif

      default: begin
        // Unreachable encodings fall back to a quiet IDLE.
        state_d      = ST_IDLE;
        counter_d    = ADDR_ZERO;
        busy_d       = 1'b0;
        valid_out_d  = 1'b0;
        frame_done_d = 1'b0;
        rd_en_d      = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      counter_q    <= ADDR_ZERO;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      rd_addr_q    <= ADDR_ZERO;
      rd_en_q      <= 1'b0;
      pixel_out_q  <= {PIXEL_W{1'b0}};
      valid_out_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      rd_addr_q    <= rd_addr_d;
      rd_en_q      <= rd_en_d;
      pixel_out_q  <= pixel_out_d;
      valid_out_q  <= valid_out_d;
    end
  end

`ifdef PIXEL_FRAME_STREAMER_CHECKSUM_EN
  // Checksum accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= {PIXEL_W{1'b0}};
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign rd_addr    = rd_addr_q;
  assign rd_en      = rd_en_q;
  assign pixel_out  = pixel_out_q;
  assign valid_out  = valid_out_q;

endmodule
